regfile_sb: RTL and testbench

Parametrised integer register file with a built-in write-bypass path and a per-register busy scoreboard, successor to the single-issue 2R1W register file. It sits between decode (read and issue) and writeback (write) in the pipelined core. It reports whether each read operand still has an in-flight producer, so the hazard unit no longer tracks destinations itself.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_sb.sv | 67 ++++++
 tb/tb_regfile_sb.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the register file with bypass and busy scoreboard.
package regfile_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int NRD_D   = 2;

    // Architectural register that always reads zero and is never busy.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, wiped on flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_D,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy;

    assign busy_vec = busy;

    // Priority: flush, then a new producer, then the writeback that retires one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy[ZERO_REG] <= 1'b0;
            for (int r = 1; r < NREGS; r++) begin
                if (iss_valid && iss_rd == AW'(r)) begin
                    busy[r] <= 1'b1;
                end else if (we && waddr == AW'(r)) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write bypass and busy reporting per read port.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int NRD   = NRD_D,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    // we and iss_valid are single-cycle qualifiers with no back-pressure:
    // the register file accepts every asserted write and issue on the edge.

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (we && waddr != AW'(ZERO_REG)) begin
            regs[waddr] <= wdata;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          hit;

        assign addr    = raddr[i*AW +: AW];
        assign is_zero = addr == AW'(ZERO_REG);
        // A matching writeback this cycle supplies the data and retires the hazard.
        assign hit     = we && (waddr == addr);

        assign rdata[i*XLEN +: XLEN] = is_zero ? '0 : (hit ? wdata : regs[addr]);
        assign rbusy[i]              = !is_zero && !hit && busy_vec[addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;

    // Wide instance: NRD=4, NREGS=16
    logic [15:0]  w_raddr;
    logic [127:0] w_rdata;
    logic [3:0]   w_rbusy;
    logic         w_we;
    logic [3:0]   w_waddr;
    logic [31:0]  w_wdata;
    logic         w_iss_valid;
    logic [3:0]   w_iss_rd;
    logic         w_flush;
    logic [15:0]  w_busy_vec;

    // Narrow instance: NRD=1, XLEN=64
    logic [4:0]  n_raddr;
    logic [63:0] n_rdata;
    logic [0:0]  n_rbusy;
    logic        n_we;
    logic [4:0]  n_waddr;
    logic [63:0] n_wdata;
    logic        n_iss_valid;
    logic [4:0]  n_iss_rd;
    logic        n_flush;
    logic [31:0] n_busy_vec;

    int n_pass;
    int n_total;

    // Reference model: architectural contents and set of pending destinations
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) u_dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .flush(flush), .busy_vec(busy_vec)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .NRD(4)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .raddr(w_raddr), .rdata(w_rdata), .rbusy(w_rbusy),
        .we(w_we), .waddr(w_waddr), .wdata(w_wdata), .iss_valid(w_iss_valid),
        .iss_rd(w_iss_rd), .flush(w_flush), .busy_vec(w_busy_vec)
    );

    regfile_sb #(.XLEN(64), .NREGS(32), .NRD(1)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n), .raddr(n_raddr), .rdata(n_rdata), .rbusy(n_rbusy),
        .we(n_we), .waddr(n_waddr), .wdata(n_wdata), .iss_valid(n_iss_valid),
        .iss_rd(n_iss_rd), .flush(n_flush), .busy_vec(n_busy_vec)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    function automatic void model_clock();
        if (we && waddr != 0) m_regs[waddr] = wdata;
        if (flush) begin
            for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
        end else begin
            if (we) m_busy[waddr] = 1'b0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_rbusy(logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (we && waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [NREGS-1:0] exp_busy_vec();
        logic [NREGS-1:0] v;
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        w_we = 1'b0; w_waddr = '0; w_wdata = '0; w_iss_valid = 1'b0; w_iss_rd = '0; w_flush = 1'b0;
        n_we = 1'b0; n_waddr = '0; n_wdata = '0; n_iss_valid = 1'b0; n_iss_rd = '0; n_flush = 1'b0;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(int p, logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        raddr = '0;
        set_raddr(0, 5'd5);
        set_raddr(1, 5'd17);
        model_reset();
        #3;
        n_total++;
        if (rdata !== '0) $display("FAIL reset_rdata: got %h exp %h", rdata, {NRD*XLEN{1'b0}});
        else n_pass++;
        n_total++;
        if (rbusy !== '0) $display("FAIL reset_rbusy: got %b exp 0", rbusy);
        else n_pass++;
        n_total++;
        if (busy_vec !== '0) $display("FAIL reset_busy_vec: got %h exp 0", busy_vec);
        else n_pass++;
        we = 1'b1; waddr = 5'd5; wdata = 32'hCAFE_0001;
        #1;
        n_total++;
        if (rdata[XLEN-1:0] !== 32'hCAFE_0001) $display("FAIL reset_bypass: got %h exp %h", rdata[XLEN-1:0], 32'hCAFE_0001);
        else n_pass++;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd8;
        tick();
        idle();
        set_raddr(0, 5'd5);
        set_raddr(1, 5'd8);
        #1;
        n_total++;
        if (rdata[XLEN-1:0] !== 32'hDEAD_BEEF || rbusy[0] !== 1'b0)
            $display("FAIL write_read_r5: got %h/%b exp deadbeef/0", rdata[XLEN-1:0], rbusy[0]);
        else n_pass++;
        n_total++;
        if (rbusy[1] !== 1'b1) $display("FAIL busy_r8: got %b exp 1", rbusy[1]);
        else n_pass++;
        // Mid-cycle reset with a write and an issue in flight
        we = 1'b1; waddr = 5'd6; wdata = 32'h6666_6666;
        iss_valid = 1'b1; iss_rd = 5'd9;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (rdata[XLEN-1:0] !== '0) $display("FAIL midreset_rdata: got %h exp 0", rdata[XLEN-1:0]);
        else n_pass++;
        n_total++;
        if (busy_vec !== '0) $display("FAIL midreset_busy_vec: got %h exp 0", busy_vec);
        else n_pass++;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        set_raddr(0, 5'd6);
        #1;
        n_total++;
        if (rdata[XLEN-1:0] !== '0) $display("FAIL lost_write_r6: got %h exp 0", rdata[XLEN-1:0]);
        else n_pass++;
    endtask

    task automatic test_r0();
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        idle();
        set_raddr(0, 5'd0);
        set_raddr(1, 5'd0);
        #1;
        n_total++;
        if (rdata !== '0 || rbusy !== '0) $display("FAIL r0_read: got %h/%b exp 0/0", rdata, rbusy);
        else n_pass++;
        n_total++;
        if (busy_vec[0] !== 1'b0) $display("FAIL r0_busy: got %b exp 0", busy_vec[0]);
        else n_pass++;
    endtask

    task automatic test_bypass();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        idle();
        set_raddr(0, 5'd7);
        set_raddr(1, 5'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++;
            if (rbusy[0] !== 1'b1) $display("FAIL hold_busy_r7 cycle %0d: got %b exp 1", c, rbusy[0]);
            else n_pass++;
            tick();
        end
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5;
        #1;
        n_total++;
        if (rdata[XLEN-1:0] !== 32'hA5 || rbusy[0] !== 1'b0)
            $display("FAIL bypass_r7: got %h/%b exp a5/0", rdata[XLEN-1:0], rbusy[0]);
        else n_pass++;
        n_total++;
        if (busy_vec[7] !== 1'b1) $display("FAIL busy_vec_before_wb: got %b exp 1", busy_vec[7]);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (busy_vec[7] !== 1'b0 || rdata[XLEN-1:0] !== 32'hA5)
            $display("FAIL after_wb_r7: got %b/%h exp 0/a5", busy_vec[7], rdata[XLEN-1:0]);
        else n_pass++;
    endtask

    task automatic test_issue_and_wb_same();
        we = 1'b1; waddr = 5'd9; wdata = 32'h9999_0009;
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        idle();
        set_raddr(0, 5'd9);
        #1;
        n_total++;
        if (busy_vec[9] !== 1'b1 || rbusy[0] !== 1'b1)
            $display("FAIL iss_wins_r9: got %b/%b exp 1/1", busy_vec[9], rbusy[0]);
        else n_pass++;
        n_total++;
        if (rdata[XLEN-1:0] !== 32'h9999_0009) $display("FAIL written_r9: got %h exp 99990009", rdata[XLEN-1:0]);
        else n_pass++;
    endtask

    task automatic test_flush();
        we = 1'b1; waddr = 5'd3; wdata = 32'h3333;
        tick();
        we = 1'b1; waddr = 5'd10; wdata = 32'hAAAA;
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        idle();
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd11;
        tick();
        idle();
        set_raddr(0, 5'd3);
        set_raddr(1, 5'd10);
        #1;
        n_total++;
        if (busy_vec !== '0) $display("FAIL flush_busy_vec: got %h exp 0", busy_vec);
        else n_pass++;
        n_total++;
        if (rdata !== {32'hAAAA, 32'h3333}) $display("FAIL flush_contents: got %h exp %h", rdata, {32'hAAAA, 32'h3333});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int c = 0; c < 300; c++) begin
            we        = 1'($urandom_range(0, 1));
            waddr     = AW'($urandom_range(0, 7));
            wdata     = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NRD; p++) set_raddr(p, AW'($urandom_range(0, 7)));
            #1;
            for (int p = 0; p < NRD; p++) begin
                a = raddr[p*AW +: AW];
                n_total++;
                if (rdata[p*XLEN +: XLEN] !== exp_rdata(a))
                    $display("FAIL rand_rdata c%0d p%0d r%0d: got %h exp %h", c, p, a, rdata[p*XLEN +: XLEN], exp_rdata(a));
                else n_pass++;
                n_total++;
                if (rbusy[p] !== exp_rbusy(a))
                    $display("FAIL rand_rbusy c%0d p%0d r%0d: got %b exp %b", c, p, a, rbusy[p], exp_rbusy(a));
                else n_pass++;
            end
            n_total++;
            if (busy_vec !== exp_busy_vec()) $display("FAIL rand_busy_vec c%0d: got %h exp %h", c, busy_vec, exp_busy_vec());
            else n_pass++;
            tick();
        end
        idle();
    endtask

    task automatic test_param_sweep();
        w_we = 1'b1; w_waddr = 4'd1; w_wdata = 32'h1111_0001;
        n_we = 1'b1; n_waddr = 5'd3; n_wdata = 64'h0123_4567_89AB_CDEF;
        tick();
        idle();
        w_we = 1'b1; w_waddr = 4'd15; w_wdata = 32'hFFFF_000F;
        w_iss_valid = 1'b1; w_iss_rd = 4'd2;
        n_raddr = 5'd3;
        #1;
        n_total++;
        if (n_rdata !== 64'h0123_4567_89AB_CDEF || n_rbusy !== 1'b0)
            $display("FAIL narrow_read_r3: got %h/%b exp 0123456789abcdef/0", n_rdata, n_rbusy);
        else n_pass++;
        tick();
        idle();
        w_we = 1'b1; w_waddr = 4'd2; w_wdata = 32'h2222_BEEF;
        w_raddr = {4'd15, 4'd1, 4'd2, 4'd1};
        n_we = 1'b1; n_waddr = 5'd3; n_wdata = 64'hFEDC_BA98_7654_3210;
        #1;
        n_total++;
        if (w_rdata !== {32'hFFFF_000F, 32'h1111_0001, 32'h2222_BEEF, 32'h1111_0001})
            $display("FAIL wide_ports: got %h exp %h", w_rdata, {32'hFFFF_000F, 32'h1111_0001, 32'h2222_BEEF, 32'h1111_0001});
        else n_pass++;
        n_total++;
        if (w_rbusy !== 4'b0000 || w_busy_vec !== 16'h0004)
            $display("FAIL wide_busy: got %b/%h exp 0000/0004", w_rbusy, w_busy_vec);
        else n_pass++;
        n_total++;
        if (n_rdata !== 64'hFEDC_BA98_7654_3210) $display("FAIL narrow_bypass: got %h exp fedcba9876543210", n_rdata);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (w_busy_vec !== 16'h0000 || w_rdata[63:32] !== 32'h2222_BEEF)
            $display("FAIL wide_after_wb: got %h/%h exp 0000/2222beef", w_busy_vec, w_rdata[63:32]);
        else n_pass++;
    endtask

    // ---------------- sequencing and report ----------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        raddr   = '0;
        w_raddr = '0;
        n_raddr = '0;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_issue_and_wb_same();
        test_flush();
        test_random();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
